// File: rtl/clkdiv_bank.sv
// Bank of NCH programmable dividers, each producing a 50% toggle or a single-cycle pulse.
// Config writes are staged per channel and only reach the active registers on a wrap edge.
module clkdiv_bank #(
   parameter  int NCH = 8,
   parameter  int CW  = 8,
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           sync,
   input  logic           cfg_valid,
   output logic           cfg_ready,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [CW-1:0]  cfg_div,
   input  logic           cfg_en,
   input  logic           cfg_pulse,
   output logic [NCH-1:0] sig_out
);

   // Power-on divide value: channel i runs with an output period of 2^(i+1).
   function automatic logic [CW-1:0] reset_div(input int ch);
      if (ch >= CW) return '1;
      return CW'((32'd1 << ch) - 32'd1);
   endfunction

   logic [CW-1:0]  div_q  [NCH];
   logic [CW-1:0]  div_d  [NCH];
   logic [CW-1:0]  cnt_q  [NCH];
   logic [CW-1:0]  cnt_d  [NCH];
   logic [CW-1:0]  pdiv_q [NCH];
   logic [CW-1:0]  pdiv_d [NCH];

   logic [NCH-1:0] en_q,     en_d;
   logic [NCH-1:0] pulse_q,  pulse_d;
   logic [NCH-1:0] out_q,    out_d;
   logic [NCH-1:0] pen_q,    pen_d;
   logic [NCH-1:0] ppulse_q, ppulse_d;
   logic [NCH-1:0] pflag_q,  pflag_d;

   logic [NCH-1:0] ch_sel;
   logic [NCH-1:0] wr_sel;
   logic [NCH-1:0] wrap;
   logic           wr_acc;

   // An out-of-range cfg_ch decodes to no channel, so it reads as ready and writes nothing.
   always_comb begin
      ch_sel = '0;
      for (int i = 0; i < NCH; i++) begin
         ch_sel[i] = (cfg_ch == CHW'(i));
      end
   end

   assign cfg_ready = ~|(ch_sel & pflag_q);
   assign wr_acc    = cfg_valid & cfg_ready;
   assign wr_sel    = ch_sel & {NCH{wr_acc}};

   always_comb begin
      wrap = '0;
      for (int i = 0; i < NCH; i++) begin
         wrap[i] = en_q[i] & (cnt_q[i] == div_q[i]);
      end
   end

   // NOTE: every _d starts as a copy of its _q so no path through this block leaves a
   // variable unassigned; that is what keeps synthesis from inferring latches.
   always_comb begin
      div_d    = div_q;
      cnt_d    = cnt_q;
      pdiv_d   = pdiv_q;
      en_d     = en_q;
      pulse_d  = pulse_q;
      out_d    = out_q;
      pen_d    = pen_q;
      ppulse_d = ppulse_q;
      pflag_d  = pflag_q;

      for (int i = 0; i < NCH; i++) begin
         if (sync) begin
            cnt_d[i]   = '0;
            out_d[i]   = 1'b0;
            pflag_d[i] = 1'b0;
            if (wr_sel[i]) begin
               div_d[i]   = cfg_div;
               en_d[i]    = cfg_en;
               pulse_d[i] = cfg_pulse;
            end else if (pflag_q[i]) begin
               div_d[i]   = pdiv_q[i];
               en_d[i]    = pen_q[i];
               pulse_d[i] = ppulse_q[i];
            end
         end else begin
            if (en_q[i]) begin
               cnt_d[i] = wrap[i] ? '0 : cnt_q[i] + CW'(1);
               out_d[i] = pulse_q[i] ? wrap[i] : (out_q[i] ^ wrap[i]);
            end else begin
               cnt_d[i] = '0;
               out_d[i] = 1'b0;
            end

            // The wrap edge still finishes under the old config; the new one starts from cnt=0.
            if (pflag_q[i] && (wrap[i] || !en_q[i])) begin
               div_d[i]   = pdiv_q[i];
               en_d[i]    = pen_q[i];
               pulse_d[i] = ppulse_q[i];
               pflag_d[i] = 1'b0;
            end else if (wr_sel[i]) begin
               pdiv_d[i]   = cfg_div;
               pen_d[i]    = cfg_en;
               ppulse_d[i] = cfg_pulse;
               pflag_d[i]  = 1'b1;
            end
         end
      end
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   // NOTE: these per-channel arrays are ordinary flops, not RAM, so all of them get a reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            div_q[i]  <= reset_div(i);
            cnt_q[i]  <= '0;
            pdiv_q[i] <= '0;
         end
         en_q     <= '1;
         pulse_q  <= '0;
         out_q    <= '0;
         pen_q    <= '0;
         ppulse_q <= '0;
         pflag_q  <= '0;
      end else begin
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         pdiv_q   <= pdiv_d;
         en_q     <= en_d;
         pulse_q  <= pulse_d;
         out_q    <= out_d;
         pen_q    <= pen_d;
         ppulse_q <= ppulse_d;
         pflag_q  <= pflag_d;
      end
   end

   assign sig_out = out_q;

endmodule

// File: doc/clkdiv_bank.md
CLKDIV_BANK -- requirements
Module: clkdiv_bank

Interface
REQ-001 Parameter NCH, default 8: number of divider channels, range 1..32.
REQ-002 Parameter CW, default 8: divide-value and counter width, range 2..16.
REQ-003 Localparam CHW = max(1, clog2(NCH)): channel-index width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 sync  input  1  synchronous phase-align strobe, active-high.
REQ-007 cfg_valid  input  1  config write request.
REQ-008 cfg_ready  output  1  config write can be accepted this cycle.
REQ-009 cfg_ch  input  CHW  target channel index.
REQ-010 cfg_div  input  CW  divide value D.
REQ-011 cfg_en  input  1  channel enable.
REQ-012 cfg_pulse  input  1  mode select: 1 = pulse mode, 0 = toggle mode.
REQ-013 sig_out  output  NCH  registered channel outputs, bit i = channel i.

Function
REQ-014 Each channel SHALL hold the registers div[CW], en, pulse, cnt[CW] and out, plus a pending copy (pdiv, pen, ppulse, pflag).
REQ-015 Enabled channel: if cnt != div, cnt SHALL increment by 1 per clk; if cnt == div (a wrap), cnt SHALL go to 0 on the next edge.
REQ-016 Toggle mode: out SHALL invert on each wrap; the period is 2*(D+1) clk cycles and the duty cycle is 50%.
REQ-017 Pulse mode: out SHALL be 1 for exactly the one cycle following each wrap and 0 otherwise; the period is D+1 cycles.
REQ-018 Pulse mode with D=0 SHALL hold out constantly 1 while the channel is enabled.
REQ-019 Disabled channel: cnt SHALL be held at 0 and out SHALL be 0 from the next edge onward.
REQ-020 Handshake: a write is accepted on an edge where cfg_valid && cfg_ready.
REQ-021 cfg_ready SHALL be combinational and equal ~pflag[cfg_ch].
REQ-022 An accepted write SHALL load the pending registers and set pflag.
REQ-023 Glitch-free update: pending config SHALL transfer to the active registers, and clear pflag, on the channel's next wrap edge.
REQ-024 The wrap edge that performs the transfer SHALL itself complete the toggle or pulse under the old config.
REQ-025 If the channel is disabled at accept time, the transfer SHALL occur on the edge following acceptance.
REQ-026 cfg_ch >= NCH: cfg_ready SHALL be 1; an accepted write is discarded and no state changes.
REQ-027 sync=1 SHALL, on that edge, clear every cnt and out to 0 and apply every pending config, clearing all pflag.
REQ-028 sync takes priority over wrap and count.
REQ-029 sync and an accepted write on the same edge: the new write SHALL be applied immediately to active registers with pflag left 0.
REQ-030 A write while pflag is set is impossible because cfg_ready=0; cfg_valid SHALL be ignored in that case.
REQ-031 Counter arithmetic is unsigned CW-bit.
REQ-032 Active-register update rule: when a new div is applied, cnt is 0 at that moment and the next wrap occurs after D+1 cycles.
REQ-033 There is no internal clock gating and no derived clocks; every output is a flop in the clk domain.

Reset
REQ-034 rst_n=0 SHALL immediately clear sig_out, cnt and pflag to 0, independent of clk.
REQ-035 Reset SHALL set en=1 and pulse=0 on every channel.
REQ-036 Reset SHALL set div_i = 2^i - 1, saturated to all-ones for CW bits, so channel i out period = 2^(i+1) clk cycles.
REQ-037 After reset, cfg_ready SHALL be 1.
REQ-038 Assertion of rst_n mid-operation SHALL discard pending writes.
REQ-039 After rst_n release, out_i SHALL first rise after rising edge number 2^i.

Verification
REQ-040 Reset release, defaults -> sig_out[0] toggles every cycle, sig_out[3] period 16, sig_out[7] period 256 (NCH=8, CW=8); all outputs 0 before the first qualifying edge.
REQ-041 Write ch2 D=4 toggle mid-period -> old period 8 completes, then period 10, with no pulse shorter than 4 cycles; cfg_ready low for ch2 until the wrap, then high.
REQ-042 Write ch5 D=2 pulse -> one-cycle high pulse every 3 cycles; then D=0 pulse -> constant 1.
REQ-043 Write ch1 en=0 -> sig_out[1]=0 within 2 edges; re-enable with D=1 -> first rise after 2 edges.
REQ-044 sync asserted with all channels running and a pending write on ch4 -> all bits 0 next cycle; ch4 uses the new D immediately; all outputs restart in phase.
REQ-045 rst_n pulsed low asynchronously between edges while writes are pending -> sig_out 0 immediately; defaults restored; pending writes lost; cfg_ch=9 write (NCH=8) -> no effect.
